window_generator: RTL and testbench

WINDOW_GENERATOR -- requirements
Module: window_generator

---
 rtl/window_generator_pkg.sv | 9 +
 rtl/window_generator_line_buffer.sv | 25 ++
 rtl/window_generator.sv | 136 +++++++++++++
 tb/tb_window_generator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/window_generator_pkg.sv
// Shared helpers for the sliding-window generator and its line buffers.
package window_generator_pkg;

  // Bit width able to index 0..n-1; kept at least 1 so degenerate sizes still elaborate.
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_generator_line_buffer.sv
// One image line of storage: simple dual-port, read-before-write, registered read.
module line_buffer
  import window_generator_pkg::*;
#(
  parameter  int DEPTH = 640,
  parameter  int WIDTH = 12,
  localparam int AW    = coord_w(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/window_generator.sv
// Sliding WINDOW_SIZE x WINDOW_SIZE window over a raster pixel stream ("valid" windows only).
// Latency: window strobe two cycles after the pixel that completes it.
module window_generator
  import window_generator_pkg::*;
#(
  parameter int PIX_DATA_W    = 12,
  parameter int WINDOW_SIZE   = 3,
  parameter int INPUTS_AMOUNT = WINDOW_SIZE ** 2,
  parameter int FRAME_W       = 640,
  parameter int FRAME_H       = 480
) (
  input  logic                                     rst_i,
  input  logic                                     clk_i,
  input  logic                                     data_valid_i,
  input  logic                                     sof_i,
  input  logic [PIX_DATA_W-1:0]                    data_i,
  output logic                                     data_valid_o,
  output logic [INPUTS_AMOUNT-1:0][PIX_DATA_W-1:0] data_o
);

  localparam int XW  = coord_w(FRAME_W);
  localparam int YW  = coord_w(FRAME_H);
  localparam int NLB = WINDOW_SIZE - 1;

  logic [XW-1:0]         x_reg, x_cur, x_d1_reg;
  logic [YW-1:0]         y_reg, y_cur;
  logic                  win_done;
  logic                  valid_d1_reg, done_d1_reg, valid_d2_reg;
  logic [PIX_DATA_W-1:0] pix_d1_reg;
  logic [PIX_DATA_W-1:0] lb_rd   [NLB];
  logic [PIX_DATA_W-1:0] col     [WINDOW_SIZE];
  logic [PIX_DATA_W-1:0] win_reg [WINDOW_SIZE][WINDOW_SIZE];

  // sof forces the current pixel to (0,0); that also restarts the row gating,
  // so stale lines from an older frame can never reach a window.
  always_comb begin
    x_cur    = sof_i ? '0 : x_reg;
    y_cur    = sof_i ? '0 : y_reg;
    win_done = (x_cur >= XW'(WINDOW_SIZE - 1)) && (y_cur >= YW'(WINDOW_SIZE - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (data_valid_i) begin
      if (x_cur == XW'(FRAME_W - 1)) begin
        x_reg <= '0;
        y_reg <= (y_cur == YW'(FRAME_H - 1)) ? '0 : y_cur + 1'b1;
      end else begin
        x_reg <= x_cur + 1'b1;
        y_reg <= y_cur;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_d1_reg <= 1'b0;
      valid_d2_reg <= 1'b0;
    end else begin
      valid_d1_reg <= data_valid_i;
      valid_d2_reg <= valid_d1_reg && done_d1_reg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (data_valid_i) begin
      done_d1_reg <= win_done;
      x_d1_reg    <= x_cur;
      pix_d1_reg  <= data_i;
    end
  end

  // Buffer 0 holds line y-1; each following buffer is refilled one cycle later
  // with what its predecessor just read, so buffer i holds line y-1-i.
  generate
    for (genvar gi = 0; gi < NLB; gi++) begin : g_lb
      if (gi == 0) begin : g_head
        line_buffer #(.DEPTH(FRAME_W), .WIDTH(PIX_DATA_W)) u_lb (
          .clk    (clk_i),
          .wr_en  (data_valid_i),
          .wr_addr(x_cur),
          .wr_data(data_i),
          .rd_en  (data_valid_i),
          .rd_addr(x_cur),
          .rd_data(lb_rd[gi])
        );
      end else begin : g_tail
        line_buffer #(.DEPTH(FRAME_W), .WIDTH(PIX_DATA_W)) u_lb (
          .clk    (clk_i),
          .wr_en  (valid_d1_reg),
          .wr_addr(x_d1_reg),
          .wr_data(lb_rd[gi-1]),
          .rd_en  (data_valid_i),
          .rd_addr(x_cur),
          .rd_data(lb_rd[gi])
        );
      end
    end
    for (genvar gi = 0; gi < NLB; gi++) begin : g_col
      assign col[gi] = lb_rd[NLB-1-gi];
    end
  endgenerate

  assign col[NLB] = pix_d1_reg;

  // Columns enter on the right and age leftwards; row 0 is the oldest line.
  always_ff @(posedge clk_i) begin
    if (valid_d1_reg) begin
      for (int r = 0; r < WINDOW_SIZE; r++) begin
        for (int c = 0; c < WINDOW_SIZE - 1; c++) begin
          win_reg[r][c] <= win_reg[r][c+1];
        end
        win_reg[r][WINDOW_SIZE-1] <= col[r];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_valid_o <= 1'b0;
      data_o       <= '0;
    end else begin
      data_valid_o <= valid_d2_reg;
      if (valid_d2_reg) begin
        for (int r = 0; r < WINDOW_SIZE; r++) begin
          for (int c = 0; c < WINDOW_SIZE; c++) begin
            data_o[r*WINDOW_SIZE+c] <= win_reg[r][c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_window_generator.sv
// Self-checking bench: a hand-filled vector table for one frame, then directed
// multi-cycle sequences checked by a pixel-store scoreboard.
module tb_window_generator;

  localparam int PW = 8;
  localparam int WS = 3;
  localparam int NA = WS * WS;
  localparam int FW = 5;
  localparam int FH = 4;
  localparam int NV = 22;

  logic                   clk = 1'b0;
  logic                   rst, dv, sof;
  logic [PW-1:0]          din;
  logic                   dvo;
  logic [NA-1:0][PW-1:0]  dout;

  always #5 clk = ~clk;

  window_generator #(
    .PIX_DATA_W(PW), .WINDOW_SIZE(WS), .INPUTS_AMOUNT(NA), .FRAME_W(FW), .FRAME_H(FH)
  ) dut (
    .rst_i(rst), .clk_i(clk), .data_valid_i(dv), .sof_i(sof), .data_i(din),
    .data_valid_o(dvo), .data_o(dout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [NA*PW-1:0] act, input logic [NA*PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int                 due;
    logic [NA*PW-1:0]   win;
  } exp_t;

  exp_t          exp_q[$];
  logic [PW-1:0] fb [FH][FW];
  int            bx = 0, by = 0;
  bit            mon_en = 0;
  int            n_win = 0, n_push = 0;

  always @(negedge clk) begin
    if (mon_en && dvo) begin : mon
      exp_t e;
      n_win++;
      if (exp_q.size() == 0) begin
        chk("spurious_window", n_win, n_push);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("window%0d_cycle", n_win), cyc, e.due);
        chk($sformatf("window%0d_data", n_win), dout, e.win);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dv = 1'b0; sof = 1'b0;
    end
  endtask

  // Drive one pixel after 'gap' idle cycles (idle cycles carry junk sof/data).
  task automatic send(input logic [PW-1:0] d, input bit s, input int gap);
    exp_t e;
    repeat (gap) begin
      @(negedge clk);
      dv = 1'b0; sof = 1'($urandom); din = PW'($urandom);
    end
    @(negedge clk);
    dv = 1'b1; sof = s; din = d;
    if (s) begin bx = 0; by = 0; end
    fb[by][bx] = d;
    if (bx >= WS-1 && by >= WS-1) begin
      for (int r = 0; r < WS; r++)
        for (int c = 0; c < WS; c++)
          e.win[(r*WS+c)*PW +: PW] = fb[by-WS+1+r][bx-WS+1+c];
      e.due = cyc + 3;
      exp_q.push_back(e);
      n_push++;
    end
    if (bx == FW-1) begin
      bx = 0;
      by = (by == FH-1) ? 0 : by + 1;
    end else begin
      bx = bx + 1;
    end
  endtask

  task automatic send_frame(input logic [PW-1:0] tag, input bit first_sof, input int max_gap, input int npix);
    for (int p = 0; p < npix; p++)
      send(PW'(tag + (p / FW) * 16 + (p % FW)), first_sof && (p == 0), $urandom_range(0, max_gap));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          dv, sof;
    logic [PW-1:0] d;
    logic          ev;
    logic [PW-1:0] e0, e4, e8;
  } vec_t;

  vec_t vt[NV];

  task automatic set_exp(input int i, input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [PW-1:0] c);
    vt[i].ev = 1'b1; vt[i].e0 = a; vt[i].e4 = b; vt[i].e8 = c;
  endtask

  int w0;

  initial begin
    rst = 1'b1; dv = 1'b0; sof = 1'b0; din = '0;
    for (int i = 0; i < NV; i++) begin
      vt[i].dv  = (i < FW*FH);
      vt[i].sof = (i == 0);
      vt[i].d   = (i < FW*FH) ? PW'((i / FW) * 16 + (i % FW)) : '0;
      vt[i].ev  = 1'b0;
      vt[i].e0 = '0; vt[i].e4 = '0; vt[i].e8 = '0;
    end
    // Output visible two edges after completing pixels 12,13,14,17,18,19.
    set_exp(14, 8'h00, 8'h11, 8'h22);
    set_exp(15, 8'h01, 8'h12, 8'h23);
    set_exp(16, 8'h02, 8'h13, 8'h24);
    set_exp(19, 8'h10, 8'h21, 8'h32);
    set_exp(20, 8'h11, 8'h22, 8'h33);
    set_exp(21, 8'h12, 8'h23, 8'h34);
    for (int i = 1; i < NV; i++)
      if (!vt[i].ev) begin
        vt[i].e0 = vt[i-1].e0; vt[i].e4 = vt[i-1].e4; vt[i].e8 = vt[i-1].e8;
      end

    repeat (3) @(negedge clk);
    chk("reset_valid", dvo, 0);
    chk("reset_data", dout, 0);
    rst = 1'b0;

    @(negedge clk);
    dv = vt[0].dv; sof = vt[0].sof; din = vt[0].d;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), dvo, vt[i].ev);
      chk($sformatf("vec%0d_e0", i), dout[0], vt[i].e0);
      chk($sformatf("vec%0d_e4", i), dout[4], vt[i].e4);
      chk($sformatf("vec%0d_e8", i), dout[8], vt[i].e8);
      if (i + 1 < NV) begin
        dv = vt[i+1].dv; sof = vt[i+1].sof; din = vt[i+1].d;
      end
    end
    idle(2);
    mon_en = 1'b1;

    // Frame with random gaps: same six windows, each exactly two cycles late.
    w0 = n_win;
    send_frame(8'h00, 1'b1, 3, FW*FH);
    idle(5);
    chk("gap_frame_windows", n_win - w0, 6);

    // Two frames back to back, sof only on the first.
    w0 = n_win;
    send_frame(8'h00, 1'b1, 0, FW*FH);
    send_frame(8'h00, 1'b0, 0, FW*FH);
    idle(5);
    chk("two_frame_windows", n_win - w0, 12);

    // sof at pixel (3,2): old (2,2) window, then only post-sof (tagged) windows.
    w0 = n_win;
    send_frame(8'h40, 1'b1, 0, 2*FW + 3);
    send_frame(8'h80, 1'b1, 1, FW*FH);
    idle(5);
    chk("mid_sof_windows", n_win - w0, 7);

    // Reset one cycle after (2,2) is accepted drops its window.
    w0 = n_win;
    send_frame(8'h00, 1'b1, 0, 2*FW + 3);
    @(negedge clk);
    dv = 1'b0; sof = 1'b0; rst = 1'b1;
    n_push = n_push - exp_q.size();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("post_reset_valid", dvo, 0);
    chk("post_reset_data", dout, 0);
    idle(4);
    chk("reset_drop_windows", n_win - w0, 0);
    bx = 0; by = 0;
    send_frame(8'h80, 1'b0, 0, FW*FH);
    idle(5);
    chk("after_reset_windows", n_win - w0, 6);

    // Random data, random gaps, occasional sof mid-frame.
    for (int p = 0; p < 400; p++)
      send(PW'($urandom), (p == 0) || ($urandom_range(0, 39) == 0), $urandom_range(0, 2));
    idle(6);

    chk("total_windows", n_win, n_push);
    chk("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
